serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 bin  input  1  borrow-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while state is RUN or DONE.
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out (1 when a < b + bin, unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE -> RUN when start=1; a, b and bin are loaded into shift registers and the borrow register; the bit counter is cleared.
REQ-014 RUN SHALL process one bit per clock, LSB first, via the full-subtractor equations: d = x^y^br; br_next = (~x&y) | (~(x^y)&br).
REQ-015 Each RUN cycle SHALL shift d into the result register MSB-first, so that after WIDTH bits bit 0 sits at diff[0].
REQ-016 RUN -> DONE after exactly WIDTH processed bits; counter width = ceil(log2(WIDTH+1)).
REQ-017 done SHALL be high for exactly one cycle in DONE, asserting WIDTH clock edges after the edge that sampled start; DONE -> IDLE unconditionally.
REQ-018 start in RUN or DONE SHALL be ignored (no queuing); input changes after capture SHALL NOT affect the result.
REQ-019 diff and bout SHALL be updated only at RUN completion and SHALL hold until the next accepted start.
REQ-020 Back-to-back operation: start held high SHALL re-launch on the first IDLE cycle after DONE.

Reset
REQ-021 On rst=1 at a clock edge the state SHALL become IDLE and busy=0, done=0, diff=0, bout=0 (ovf=0 when compiled in).
REQ-022 rst SHALL take priority over start and abort an in-flight RUN; no done pulse SHALL follow.

Configuration
REQ-023 Macro SERIAL_SUB_OVF_EN: when defined, add output ovf (1 bit) = signed two's-complement overflow of a - b - bin, computed as the XOR of the borrows into and out of the MSB, registered with diff and held alongside it.
REQ-024 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-025 WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> done 8 edges later, diff=0x02, bout=0.
REQ-026 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-027 With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
REQ-028 start at 3 cycles into RUN with different a/b -> ignored; result matches the first operands; exactly one done pulse.
REQ-029 rst asserted 4 cycles into RUN -> next cycle busy=0, diff=0, bout=0; no done; a subsequent start completes normally.
REQ-030 start held high continuously for 3 operations -> done pulses spaced WIDTH+2 cycles apart, each result correct.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first, one bit per clock.
// Latency WIDTH cycles from accepted start to done; start is ignored while busy.
// Optional signed overflow output when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             x_bit, y_bit, d_bit, br_nxt;

    always_comb begin
        x_bit  = a_sr_q[0];
        y_bit  = b_sr_q[0];
        d_bit  = x_bit ^ y_bit ^ br_q;
        br_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Last bit: br_q is the borrow into the MSB, br_nxt the borrow out.
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
                    ovf_d   = br_q ^ br_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor checks them.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: plain integer arithmetic, unsigned for diff/bout and signed for overflow.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin, input int acc);
        exp_t e;
        int   r, sr;
        r  = int'(ma) - int'(mb) - int'(mbin);
        sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.diff = r[W-1:0];
        e.bout = (r < 0);
        e.ovf  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        e.cyc  = acc + W;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("diff", 32'(diff), 32'(e.diff));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("done_latency", 32'(cyc), 32'(e.cyc));
                chk("busy_in_done", 32'(busy), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Drive one start; returns after the accepting edge with start deasserted.
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                          input logic lbin, input bit expect_result);
        @(negedge clk);
        a = la; b = lb; bin = lbin; start = 1'b1;
        @(posedge clk);
        #1;
        if (expect_result) exp_q.push_back(model(la, lb, lbin, cyc));
        start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lbin);
        launch(la, lb, lbin, 1'b1);
        repeat (W + 1) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_diff", 32'(diff), 32'd0);
        chk("reset_bout", 32'(bout), 32'd0);

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);

        // start mid-RUN with other operands must be ignored
        launch(8'h9A, 8'h3C, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'h11; b = 8'hEE; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (W + 2) @(posedge clk);
        chk("ignored_start_drained", 32'(exp_q.size()), 32'd0);

        // reset aborts an in-flight operation
        launch(8'h33, 8'h44, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        repeat (W + 4) @(posedge clk);
        run_op(8'h33, 8'h44, 1'b1);

        // start held high: relaunch every W+2 cycles
        begin
            logic [W-1:0] ba[3], bb[3];
            logic         bc[3];
            for (int i = 0; i < 3; i++) begin
                ba[i] = W'($urandom); bb[i] = W'($urandom); bc[i] = 1'($urandom);
            end
            @(negedge clk);
            a = ba[0]; b = bb[0]; bin = bc[0]; start = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                exp_q.push_back(model(ba[i], bb[i], bc[i], cyc));
                if (i < 2) begin
                    a = ba[i+1]; b = bb[i+1]; bin = bc[i+1];
                    repeat (W + 1) @(posedge clk);
                end else begin
                    start = 1'b0;
                end
            end
            repeat (W + 2) @(posedge clk);
        end

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (W + 4) @(posedge clk);
        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
